// File: rtl/platform_compositor_pkg.sv
// Shared types, default colours and the inclusive box-hit helper used by
// the platform compositor and its platform table. No ports.
package platform_pkg;

    localparam int MAX_COORD_W = 16;

    // Signed working type, two bits wider than any coordinate.
    typedef logic signed [MAX_COORD_W+1:0] scoord_t;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
        logic [MAX_COORD_W-1:0] hw;
        logic [MAX_COORD_W-1:0] hh;
        logic                   vis;
    } plat_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEF_PLAT_RGB   = 24'h66BB11;
    localparam rgb_t DEF_BALL_RGB   = 24'hCAC52E;
    localparam rgb_t DEF_CANNON_RGB = 24'hFF0000;

    // |px-cx| <= hw and |py-cy| <= hh; size 0 is a single pixel.
    function automatic bit in_box(
        input scoord_t px,
        input scoord_t py,
        input scoord_t cx,
        input scoord_t cy,
        input scoord_t hw,
        input scoord_t hh
    );
        scoord_t dx;
        scoord_t dy;
        dx = px - cx;
        dy = py - cy;
        if (dx[MAX_COORD_W+1]) dx = -dx;
        if (dy[MAX_COORD_W+1]) dy = -dy;
        return (dx <= hw) && (dy <= hh);
    endfunction

endpackage

// File: rtl/platform_compositor_plat_table.sv
// Shadow/active platform table with write port, frame_start commit and scroll latch.
// Ports: Clk, Reset_n, frame_start, wr_* write port, scroll_y in; act_tbl, act_scroll out.
module plat_table
    import platform_pkg::*;
#(
    parameter int NUM_PLAT = 16,
    parameter int COORD_W  = 10
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        frame_start,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_PLAT)-1:0] wr_idx,
    input  logic [COORD_W-1:0]          wr_x,
    input  logic [COORD_W-1:0]          wr_y,
    input  logic [COORD_W-1:0]          wr_hw,
    input  logic [COORD_W-1:0]          wr_hh,
    input  logic                        wr_vis,
    input  logic [COORD_W-1:0]          scroll_y,
    output plat_t                       act_tbl [NUM_PLAT],
    output logic [COORD_W-1:0]          act_scroll
);

    plat_t              shadow_q [NUM_PLAT];
    plat_t              shadow_d [NUM_PLAT];
    plat_t              active_q [NUM_PLAT];
    plat_t              active_d [NUM_PLAT];
    logic [COORD_W-1:0] scroll_q;
    logic [COORD_W-1:0] scroll_d;
    plat_t              wr_ent;

    always_comb begin
        wr_ent.x   = MAX_COORD_W'(wr_x);
        wr_ent.y   = MAX_COORD_W'(wr_y);
        wr_ent.hw  = MAX_COORD_W'(wr_hw);
        wr_ent.hh  = MAX_COORD_W'(wr_hh);
        wr_ent.vis = wr_vis;

        shadow_d = shadow_q;
        if (wr_en && (32'(wr_idx) < NUM_PLAT)) begin
            shadow_d[wr_idx] = wr_ent;
        end

        // Copy from the registered shadow, so a same-cycle write
        // only becomes visible at the following frame_start.
        active_d = active_q;
        scroll_d = scroll_q;
        if (frame_start) begin
            active_d = shadow_q;
            scroll_d = scroll_y;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            scroll_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            scroll_q <= scroll_d;
        end
    end

    assign act_tbl    = active_q;
    assign act_scroll = scroll_q;

endmodule

// File: rtl/platform_compositor.sv
// Two-stage pixel compositor: platforms (scrolled), ball and cannon layers.
// Ports: Clk, Reset_n, frame_start, wr_*, scroll_y, Ball*, Cannon*, DrawX/DrawY,
// blank in; Red/Green/Blue, hit_any, hit_idx out. Macro PLAT_WRAP_EN enables
// vertical wrap of platforms scrolled past the top edge.
module platform_compositor
    import platform_pkg::*;
#(
    parameter int   NUM_PLAT   = 16,
    parameter int   COORD_W    = 10,
    parameter int   SCREEN_H   = 480,
    parameter rgb_t PLAT_RGB   = DEF_PLAT_RGB,
    parameter rgb_t BALL_RGB   = DEF_BALL_RGB,
    parameter rgb_t CANNON_RGB = DEF_CANNON_RGB
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        frame_start,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_PLAT)-1:0] wr_idx,
    input  logic [COORD_W-1:0]          wr_x,
    input  logic [COORD_W-1:0]          wr_y,
    input  logic [COORD_W-1:0]          wr_hw,
    input  logic [COORD_W-1:0]          wr_hh,
    input  logic                        wr_vis,
    input  logic [COORD_W-1:0]          scroll_y,
    input  logic [COORD_W-1:0]          BallX,
    input  logic [COORD_W-1:0]          BallY,
    input  logic [COORD_W-1:0]          Ball_size,
    input  logic [COORD_W-1:0]          CannonX,
    input  logic [COORD_W-1:0]          CannonY,
    input  logic [COORD_W-1:0]          CannonS,
    input  logic [COORD_W-1:0]          DrawX,
    input  logic [COORD_W-1:0]          DrawY,
    input  logic                        blank,
    output logic [7:0]                  Red,
    output logic [7:0]                  Green,
    output logic [7:0]                  Blue,
    output logic                        hit_any,
    output logic [$clog2(NUM_PLAT)-1:0] hit_idx
);

    localparam int IW = $clog2(NUM_PLAT);

    if (SCREEN_H < 1 || SCREEN_H > (1 << COORD_W)) begin : g_bad_screen_h
        $error("SCREEN_H out of range for COORD_W");
    end

    plat_t              act_tbl [NUM_PLAT];
    logic [COORD_W-1:0] act_scroll;

    plat_table #(
        .NUM_PLAT (NUM_PLAT),
        .COORD_W  (COORD_W)
    ) u_tbl (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_hw       (wr_hw),
        .wr_hh       (wr_hh),
        .wr_vis      (wr_vis),
        .scroll_y    (scroll_y),
        .act_tbl     (act_tbl),
        .act_scroll  (act_scroll)
    );

    logic [NUM_PLAT-1:0] hit_d, hit_q;
    logic                ball_d, ball_q;
    logic                cannon_d, cannon_q;
    logic                blank1_d, blank1_q;
    scoord_t             px, py, sy;

    always_comb begin
        px    = scoord_t'(DrawX);
        py    = scoord_t'(DrawY);
        sy    = '0;
        hit_d = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            sy = scoord_t'(act_tbl[i].y) - scoord_t'(act_scroll);
`ifdef PLAT_WRAP_EN
            if (sy[MAX_COORD_W+1]) sy = sy + scoord_t'(SCREEN_H);
            // Test both wrapped copies so a platform straddling the
            // top/bottom edge draws on both sides.
            hit_d[i] = act_tbl[i].vis && (
                in_box(px, py, scoord_t'(act_tbl[i].x), sy,
                       scoord_t'(act_tbl[i].hw), scoord_t'(act_tbl[i].hh)) ||
                in_box(px, py, scoord_t'(act_tbl[i].x),
                       sy - scoord_t'(SCREEN_H),
                       scoord_t'(act_tbl[i].hw), scoord_t'(act_tbl[i].hh)) ||
                in_box(px, py, scoord_t'(act_tbl[i].x),
                       sy + scoord_t'(SCREEN_H),
                       scoord_t'(act_tbl[i].hw), scoord_t'(act_tbl[i].hh)));
`else
            hit_d[i] = act_tbl[i].vis &&
                in_box(px, py, scoord_t'(act_tbl[i].x), sy,
                       scoord_t'(act_tbl[i].hw), scoord_t'(act_tbl[i].hh));
`endif
        end
        ball_d = in_box(px, py, scoord_t'(BallX), scoord_t'(BallY),
                        scoord_t'(Ball_size), scoord_t'(Ball_size));
        cannon_d = in_box(px, py, scoord_t'(CannonX), scoord_t'(CannonY),
                          scoord_t'(CannonS), scoord_t'(CannonS));
        blank1_d = blank;
    end

    rgb_t          rgb_d, rgb_q;
    logic          hit_any_d, hit_any_q;
    logic [IW-1:0] hit_idx_d, hit_idx_q;

    always_comb begin
        hit_idx_d = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (hit_q[i]) hit_idx_d = IW'(i);
        end
        hit_any_d = |hit_q;
        rgb_d     = '0;
        if (!blank1_q) begin
            hit_any_d = 1'b0;
            hit_idx_d = '0;
        end else if (ball_q) begin
            rgb_d = BALL_RGB;
        end else if (|hit_q) begin
            rgb_d = PLAT_RGB;
        end else if (cannon_q) begin
            rgb_d = CANNON_RGB;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hit_q     <= '0;
            ball_q    <= 1'b0;
            cannon_q  <= 1'b0;
            blank1_q  <= 1'b0;
            rgb_q     <= '0;
            hit_any_q <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            hit_q     <= hit_d;
            ball_q    <= ball_d;
            cannon_q  <= cannon_d;
            blank1_q  <= blank1_d;
            rgb_q     <= rgb_d;
            hit_any_q <= hit_any_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign Red     = rgb_q.r;
    assign Green   = rgb_q.g;
    assign Blue    = rgb_q.b;
    assign hit_any = hit_any_q;
    assign hit_idx = hit_idx_q;

endmodule

// File: tb/tb_platform_compositor.sv
// Scoreboard bench for platform_compositor: directed probes push expected
// pixels; a monitor pops and compares two cycles later.
module tb_platform_compositor;

    localparam logic [23:0] C_PLAT = 24'h66BB11;
    localparam logic [23:0] C_BALL = 24'hCAC52E;
    localparam logic [23:0] C_CAN  = 24'hFF0000;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_idx = '0;
    logic [9:0] wr_x = '0, wr_y = '0, wr_hw = '0, wr_hh = '0;
    logic       wr_vis = 1'b0;
    logic [9:0] scroll_y = '0;
    logic [9:0] BallX = 10'd100, BallY = 10'd200, Ball_size = 10'd4;
    logic [9:0] CannonX = 10'd1000, CannonY = 10'd10, CannonS = '0;
    logic [9:0] DrawX = 10'd100, DrawY = 10'd200;
    logic       blank = 1'b1;
    logic [7:0] Red, Green, Blue;
    logic       hit_any;
    logic [3:0] hit_idx;

    always #5 Clk = ~Clk;

    platform_compositor dut (
        .Clk (Clk), .Reset_n (Reset_n), .frame_start (frame_start),
        .wr_en (wr_en), .wr_idx (wr_idx), .wr_x (wr_x), .wr_y (wr_y),
        .wr_hw (wr_hw), .wr_hh (wr_hh), .wr_vis (wr_vis),
        .scroll_y (scroll_y),
        .BallX (BallX), .BallY (BallY), .Ball_size (Ball_size),
        .CannonX (CannonX), .CannonY (CannonY), .CannonS (CannonS),
        .DrawX (DrawX), .DrawY (DrawY), .blank (blank),
        .Red (Red), .Green (Green), .Blue (Blue),
        .hit_any (hit_any), .hit_idx (hit_idx)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        any;
        logic [3:0]  idx;
        logic        chk_idx;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  probe = 1'b0, pv1 = 1'b0, pv2 = 1'b0;

    always @(posedge Clk) begin
        pv1 <= probe;
        pv2 <= pv1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin : mon
        exp_t  e;
        string nm;
        if (pv2) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got rgb %02h%02h%02h expected none",
                         Red, Green, Blue);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_rgb"}, {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
                check({nm, "_any"}, {31'h0, hit_any}, {31'h0, e.any});
                if (e.chk_idx)
                    check({nm, "_idx"}, {28'h0, hit_idx}, {28'h0, e.idx});
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
        wr_en       = 1'b0;
        frame_start = 1'b0;
        probe       = 1'b0;
    endtask

    task automatic set_wr(input logic [3:0] i, input logic [9:0] x, y, hw, hh,
                          input logic v);
        wr_en  = 1'b1;
        wr_idx = i;
        wr_x   = x;
        wr_y   = y;
        wr_hw  = hw;
        wr_hh  = hh;
        wr_vis = v;
    endtask

    task automatic wr(input logic [3:0] i, input logic [9:0] x, y, hw, hh,
                      input logic v);
        step();
        set_wr(i, x, y, hw, hh, v);
    endtask

    task automatic commit();
        step();
        frame_start = 1'b1;
    endtask

    task automatic pix(input logic [9:0] x, y, input logic bl,
                       input logic [23:0] rgb, input logic any,
                       input logic [3:0] idx, input logic ck,
                       input string nm);
        exp_t e;
        step();
        DrawX = x;
        DrawY = y;
        blank = bl;
        probe = 1'b1;
        e.rgb = rgb;
        e.any = any;
        e.idx = idx;
        e.chk_idx = ck;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with the ball covering the probed pixel.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
            check("rst_any", {31'h0, hit_any}, 32'h0);
        end
        step();
        Reset_n = 1'b1;
        BallX = 10'd1000;
        BallY = 10'd1000;
        Ball_size = '0;

        pix(100, 200, 1, 24'h0, 0, 0, 0, "empty_a");
        pix(0, 0, 1, 24'h0, 0, 0, 0, "empty_b");

        // Write is shadowed until frame_start.
        wr(3, 100, 200, 8, 2, 1);
        pix(100, 200, 1, 24'h0, 0, 0, 0, "pre_commit");
        commit();
        pix(108, 202, 1, C_PLAT, 1, 3, 1, "edge_in");
        pix(109, 202, 1, 24'h0, 0, 0, 0, "edge_out_x");
        pix(92, 198, 1, C_PLAT, 1, 3, 1, "corner_in");
        pix(100, 203, 1, 24'h0, 0, 0, 0, "edge_out_y");

        // Priority: ball > lowest platform > cannon.
        wr(5, 100, 200, 4, 4, 1);
        commit();
        step();
        BallX = 100; BallY = 200; Ball_size = 4;
        CannonX = 100; CannonY = 200; CannonS = 2;
        pix(100, 200, 1, C_BALL, 1, 3, 1, "ball_wins");
        pix(104, 204, 1, C_BALL, 1, 5, 1, "ball_corner");
        step();
        BallX = 1000; BallY = 1000; Ball_size = 0;
        pix(100, 200, 1, C_PLAT, 1, 3, 1, "plat_low_idx");
        pix(104, 204, 1, C_PLAT, 1, 5, 1, "plat_slot5");
        wr(3, 100, 200, 8, 2, 0);
        wr(5, 100, 200, 4, 4, 0);
        commit();
        pix(100, 200, 1, C_CAN, 0, 0, 0, "cannon");
        pix(102, 198, 1, C_CAN, 0, 0, 0, "cannon_edge");
        pix(103, 200, 1, 24'h0, 0, 0, 0, "cannon_out");
        step();
        CannonX = 1000; CannonY = 10; CannonS = 0;

        // Scroll past the top edge.
        wr(0, 5, 10, 8, 4, 1);
        scroll_y = 12;
        commit();
        pix(0, 0, 1, C_PLAT, 1, 0, 1, "scr_top");
        pix(0, 2, 1, C_PLAT, 1, 0, 1, "scr_row2");
        pix(0, 3, 1, 24'h0, 0, 0, 0, "scr_row3");
        pix(13, 0, 1, C_PLAT, 1, 0, 1, "scr_xedge");
        pix(14, 0, 1, 24'h0, 0, 0, 0, "scr_xout");
        pix(0, 1022, 1, 24'h0, 0, 0, 0, "scr_1022");
`ifdef PLAT_WRAP_EN
        pix(0, 476, 1, C_PLAT, 1, 0, 1, "wrap_476");
        pix(0, 479, 1, C_PLAT, 1, 0, 1, "wrap_479");
`else
        pix(0, 478, 1, 24'h0, 0, 0, 0, "nowrap_478");
`endif

        // Same-cycle write and frame_start.
        scroll_y = 0;
        wr(1, 300, 300, 2, 2, 1);
        commit();
        step();
        set_wr(1, 600, 300, 2, 2, 1);
        frame_start = 1'b1;
        pix(300, 300, 1, C_PLAT, 1, 1, 1, "old_slot1");
        pix(600, 300, 1, 24'h0, 0, 0, 0, "new_pending");
        commit();
        pix(600, 300, 1, C_PLAT, 1, 1, 1, "new_slot1");
        pix(300, 300, 1, 24'h0, 0, 0, 0, "old_gone");
        pix(600, 300, 0, 24'h0, 0, 0, 0, "blanked");

        // Reset mid-frame on a lit pixel.
        pix(600, 300, 1, C_PLAT, 1, 1, 1, "pre_reset");
        step();
        step();
        Reset_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("midrst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("midrst_any", {31'h0, hit_any}, 32'h0);
        step();
        Reset_n = 1'b1;
        pix(600, 300, 1, 24'h0, 0, 0, 0, "post_reset");

        repeat (4) step();
        check("drain", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
